// File: rtl/fifo_ser_pkg.sv
// Shared types and helpers for the FIFO word serializer.
package fifo_ser_pkg;

    typedef enum logic [1:0] {IDLE, READ, LOAD, SEND} ser_state_t;

    // Beat index width; a single-beat word still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned nbeats);
        return (nbeats > 1) ? $clog2(nbeats) : 1;
    endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Word holding register that presents the current beat in its low OUT_WIDTH bits.
module ser_shift_reg #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 shift,
    input  logic [WIDTH-1:0]     din,
    output logic [OUT_WIDTH-1:0] dout
);

    logic [WIDTH-1:0] data_q;

    // Shifting right keeps slice[index] at the bottom, so dout comes straight off flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= din;
        end else if (shift) begin
            data_q <= data_q >> OUT_WIDTH;
        end
    end

    assign dout = data_q[OUT_WIDTH-1:0];

endmodule

// File: rtl/fifo_word_serializer.sv
// Drains a synchronous FIFO and emits each word as LSB-first narrow beats on a valid/ready stream.
module fifo_word_serializer
    import fifo_ser_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_rdata,
    output logic                 fifo_cs,
    output logic                 fifo_rd_en,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 busy,
    output logic [CNT_W-1:0]     words_sent
);

    localparam int unsigned NBEATS = WIDTH / OUT_WIDTH;
    localparam int unsigned IDX_W  = idx_width(NBEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    if (WIDTH % OUT_WIDTH != 0) begin : g_bad_width
        $error("fifo_word_serializer: WIDTH must be a multiple of OUT_WIDTH");
    end

    ser_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             rd_en_q, rd_en_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q;
    logic             load, shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            words_q <= '0;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            rd_en_q <= rd_en_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        words_d = words_q;
        rd_en_d = 1'b0;
        valid_d = valid_q;
        last_d  = last_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && !fifo_empty) begin
                    state_d = READ;
                    rd_en_d = 1'b1;
                end
            end
            READ: state_d = LOAD;
            LOAD: begin
                load    = 1'b1;
                idx_d   = '0;
                valid_d = 1'b1;
                last_d  = (NBEATS == 1);
                state_d = SEND;
            end
            SEND: begin
                // valid_q is always high here, so m_ready alone completes the beat.
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        words_d = words_q + CNT_W'(1);
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        if (en && !fifo_empty) begin
                            state_d = READ;
                            rd_en_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        shift  = 1'b1;
                        last_d = ((idx_q + IDX_W'(1)) == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    ser_shift_reg #(
        .WIDTH     (WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .din   (fifo_rdata),
        .dout  (m_data)
    );

    assign fifo_cs    = rd_en_q;
    assign fifo_rd_en = rd_en_q;
    assign m_valid    = valid_q;
    assign m_last     = last_q;
    assign busy       = busy_q;
    assign words_sent = words_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Scoreboard bench: a FIFO model feeds the serializer, expected beats are queued on each pop.
module tb_fifo_word_serializer;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned OUT_WIDTH = 8;
    localparam int unsigned CNT_W     = 16;
    localparam int          NBI       = WIDTH / OUT_WIDTH;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic                 fifo_empty = 1'b1;
    logic [WIDTH-1:0]     fifo_rdata = '0;
    logic                 m_ready = 1'b0;
    logic                 fifo_cs, fifo_rd_en, m_valid, m_last, busy;
    logic [OUT_WIDTH-1:0] m_data;
    logic [CNT_W-1:0]     words_sent;

    logic [WIDTH-1:0]     fq[$];
    logic [OUT_WIDTH:0]   exp_q[$];
    int checks = 0;
    int errors = 0;
    int exp_words = 0;
    int beats_seen = 0;
    int rd_cnt = 0;
    int ready_mode = 0;
    int pat_idx = 0;
    logic [3:0]           pat = 4'b1001;
    logic                 prev_stall = 1'b0, prev_rd = 1'b0, prev_empty = 1'b1, prev_last = 1'b0;
    logic [OUT_WIDTH-1:0] prev_data = '0;

    fifo_word_serializer #(
        .WIDTH     (WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_cs    (fifo_cs),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: all observation at the falling edge, away from the active edge.
    initial begin
        logic [OUT_WIDTH:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_rd_en", 64'(fifo_rd_en), 64'(0));
                check("rst_cs", 64'(fifo_cs), 64'(0));
                check("rst_valid", 64'(m_valid), 64'(0));
                check("rst_last", 64'(m_last), 64'(0));
                check("rst_data", 64'(m_data), 64'(0));
                check("rst_busy", 64'(busy), 64'(0));
                check("rst_words", 64'(words_sent), 64'(0));
                exp_q.delete();
                exp_words  = 0;
                prev_stall = 1'b0;
                prev_rd    = 1'b0;
                prev_empty = fifo_empty;
            end else begin
                check("words_sent", 64'(words_sent), 64'(CNT_W'(exp_words)));
                check("cs_eq_rd", 64'(fifo_cs), 64'(fifo_rd_en));
                if (fifo_rd_en) begin
                    rd_cnt++;
                    check("rd_when_empty", 64'(prev_empty), 64'(0));
                    check("rd_consecutive", 64'(prev_rd), 64'(0));
                end
                if (prev_stall) begin
                    check("stall_valid", 64'(m_valid), 64'(1));
                    check("stall_data", 64'(m_data), 64'(prev_data));
                    check("stall_last", 64'(m_last), 64'(prev_last));
                end
                if (m_valid && m_ready) begin
                    beats_seen++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'({m_last, m_data}), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 64'({m_last, m_data}), 64'(e));
                    end
                    if (m_last) exp_words++;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
                prev_rd    = fifo_rd_en;
                prev_empty = fifo_empty;
            end
        end
    end

    // One clock of FIFO model plus downstream ready generation.
    task automatic cyc();
        logic             rd;
        logic [WIDTH-1:0] w;
        @(negedge clk);
        rd = fifo_rd_en;
        @(posedge clk);
        #1;
        if (rd && fq.size() > 0) begin
            w = fq.pop_front();
            fifo_rdata = w;
            for (int i = 0; i < NBI; i++) begin
                exp_q.push_back({(i == NBI - 1), OUT_WIDTH'(w >> (OUT_WIDTH * i))});
            end
        end
        fifo_empty = (fq.size() == 0);
        case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = ($urandom_range(0, 9) < 7);
            2: m_ready = 1'b0;
            default: begin
                m_ready = pat[pat_idx % 4];
                pat_idx++;
            end
        endcase
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (!(fq.size() == 0 && exp_q.size() == 0 && !busy && !fifo_rd_en) && n < 3000) begin
            cyc();
            n++;
        end
        check({name, "_timeout"}, 64'(n < 3000), 64'(1));
    endtask

    initial begin
        int r0, b0, n;
        // Reset held with words waiting.
        en = 1'b1;
        @(posedge clk);
        #1;
        push_word(32'hCAFE0001);
        push_word(32'hCAFE0002);
        repeat (4) cyc();
        rst_n = 1'b1;
        drain("reset_release");

        // Single word, ready held high.
        r0 = rd_cnt;
        ready_mode = 0;
        push_word(32'hA1B2C3D4);
        drain("single");
        check("single_reads", 64'(rd_cnt - r0), 64'(1));

        // Backpressure pattern 1,0,0,1.
        ready_mode = 3;
        pat_idx = 0;
        push_word(32'h0BADF00D);
        push_word(32'h12345678);
        drain("backpressure");

        // Back-to-back words.
        ready_mode = 0;
        r0 = rd_cnt;
        push_word(32'h11111111);
        push_word(32'h22222222);
        push_word(32'h33333333);
        drain("b2b");
        check("b2b_reads", 64'(rd_cnt - r0), 64'(3));

        // en dropped on the second beat of the first word.
        r0 = rd_cnt;
        b0 = beats_seen;
        push_word(32'h55667788);
        push_word(32'h99AABBCC);
        n = 0;
        while (beats_seen < b0 + 1 && n < 200) begin
            cyc();
            n++;
        end
        check("en_drop_wait", 64'(n < 200), 64'(1));
        en = 1'b0;
        repeat (20) cyc();
        check("en_drop_reads", 64'(rd_cnt - r0), 64'(1));
        check("en_drop_busy", 64'(busy), 64'(0));
        check("en_drop_left", 64'(fq.size()), 64'(1));
        check("en_drop_beats", 64'(beats_seen - b0), 64'(NBI));
        en = 1'b1;
        drain("en_restore");

        // Reset in the middle of a word, then a fresh word.
        b0 = beats_seen;
        push_word(32'hDEADBEEF);
        n = 0;
        while (beats_seen < b0 + 2 && n < 200) begin
            cyc();
            n++;
        end
        check("midrst_wait", 64'(n < 200), 64'(1));
        ready_mode = 2;
        m_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        ready_mode = 0;
        push_word(32'hFEEDFACE);
        drain("after_midrst");

        // Randomized traffic with random en and ready.
        ready_mode = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) push_word($urandom);
            en = ($urandom_range(0, 9) != 0);
            cyc();
        end
        en = 1'b1;
        drain("random");
        check("final_exp_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
